daq_acq_ctrl: RTL and testbench

Acquisition sequencer between the AD9221 capture stage and the USB2.0 slave-FIFO writer.
- Arms on a software start and waits for a trigger (immediate or level crossing).
- Decimates the 12-bit sample stream and counts out a programmed number of samples.
- Presents the samples as 16-bit words on a valid/ready interface.
- Flags overflow when the USB side stalls.

---
 rtl/daq_acq_ctrl.sv | 211 +++++++++++++++++++++
 tb/tb_daq_acq_ctrl.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/daq_acq_ctrl.sv
// daq_acq_ctrl: acquisition sequencer between the ADC capture stage and the USB slave-FIFO writer.
// Arms on start, waits for an immediate or rising-level trigger, decimates the
// sample stream and counts out a burst onto a single-entry valid/ready register.
// Optional build macro DAQ_ACQ_HDR_EN: prepends a header word to each burst and
// routes kept samples through a one-entry skid register.
module daq_acq_ctrl #(
    parameter int SAMPLE_W = 12,
    parameter int CNT_W    = 16,
    parameter int DECIM_W  = 8
) (
    input  logic                clk_i,
    input  logic                rst_n_i,
    input  logic [SAMPLE_W-1:0] ad_data_i,
    input  logic                start_i,
    input  logic                abort_i,
    input  logic [CNT_W-1:0]    sample_num_i,
    input  logic [DECIM_W-1:0]  decim_i,
    input  logic                trig_src_i,
    input  logic [SAMPLE_W-1:0] trig_level_i,
    output logic [15:0]         data_o,
    output logic                valid_o,
    input  logic                ready_i,
    output logic                busy_o,
    output logic                done_o,
    output logic                ovf_o
);
    typedef enum logic [1:0] {IDLE, ARM, CAPT, FLUSH} state_e;

    state_e                state_q, state_d;
    logic [CNT_W-1:0]      num_q, num_d;
    logic [DECIM_W-1:0]    decim_q, decim_d;
    logic                  src_q, src_d;
    logic [SAMPLE_W-1:0]   level_q, level_d;
    logic [SAMPLE_W-1:0]   prev_q, prev_d;
    logic                  prev_vld_q, prev_vld_d;
    logic [DECIM_W-1:0]    dcnt_q, dcnt_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [15:0]           data_q, data_d;
    logic                  valid_q, valid_d;
    logic                  done_q, done_d;
    logic                  ovf_q, ovf_d;

    logic                  start_ok, abort_ok, trig, keep, last, flush_ok, wr;
    logic [DECIM_W-1:0]    dm1;
    logic [CNT_W-1:0]      cnt_inc;
    logic [SAMPLE_W-1:0]   wdata;

    assign start_ok = state_q == IDLE && start_i && !abort_i;
    assign abort_ok = state_q != IDLE && abort_i;
    // The first ARM cycle has no valid previous sample, so a level trigger cannot fire there.
    assign trig     = state_q == ARM &&
                      (!src_q || (prev_vld_q && prev_q < level_q && ad_data_i >= level_q));
    // The triggering sample is always kept; afterwards the decimation counter decides.
    assign keep     = trig || (state_q == CAPT && dcnt_q == '0);
    assign dm1      = decim_q == '0 ? '0 : decim_q - 1'b1;
    assign cnt_inc  = cnt_q + 1'b1;
    assign last     = keep && num_q != '0 && cnt_inc == num_q;

`ifdef DAQ_ACQ_HDR_EN
    logic [SAMPLE_W-1:0]   skid_q, skid_d;
    logic                  skid_vld_q, skid_vld_d;
    logic [15:0]           hdr;

    assign hdr      = 16'hA500 | {8'h00, num_q[7:0]};
    assign wr       = skid_vld_q;
    assign wdata    = skid_q;
    assign flush_ok = !skid_vld_q && (!valid_q || ready_i);
`else
    assign wr       = keep;
    assign wdata    = ad_data_i;
    assign flush_ok = !valid_q || ready_i;
`endif

    // State register
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) state_q <= IDLE;
        else          state_q <= state_d;
    end

    // Next-state logic; abort from any busy state returns to IDLE
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = start_ok ? ARM : IDLE;
            ARM:     state_d = trig ? (last ? FLUSH : CAPT) : ARM;
            CAPT:    state_d = last ? FLUSH : CAPT;
            default: state_d = flush_ok ? IDLE : FLUSH;
        endcase
        if (abort_ok) state_d = IDLE;
    end

    // State-decoded outputs
    always_comb begin
        busy_o = state_q != IDLE;
    end

    assign data_o  = data_q;
    assign valid_o = valid_q;
    assign done_o  = done_q;
    assign ovf_o   = ovf_q;

    // Datapath next values: config latch, trigger history, counters and output register
    always_comb begin
        num_d      = num_q;
        decim_d    = decim_q;
        src_d      = src_q;
        level_d    = level_q;
        prev_d     = prev_q;
        prev_vld_d = prev_vld_q;
        dcnt_d     = dcnt_q;
        cnt_d      = cnt_q;
        data_d     = data_q;
        valid_d    = valid_q;
        ovf_d      = ovf_q;
        done_d     = state_q == FLUSH && flush_ok && !abort_i;
`ifdef DAQ_ACQ_HDR_EN
        skid_d     = keep ? ad_data_i : skid_q;
        skid_vld_d = keep;
`endif
        if (start_ok) begin
            num_d      = sample_num_i;
            decim_d    = decim_i;
            src_d      = trig_src_i;
            level_d    = trig_level_i;
            ovf_d      = 1'b0;
            prev_vld_d = 1'b0;
            cnt_d      = '0;
            dcnt_d     = '0;
        end
        if (state_q == ARM) begin
            prev_d     = ad_data_i;
            prev_vld_d = 1'b1;
        end
        if (keep) begin
            cnt_d  = cnt_inc;
            dcnt_d = dm1;
        end else if (state_q == CAPT) begin
            dcnt_d = dcnt_q - 1'b1;
        end
        if (valid_q && ready_i) valid_d = 1'b0;
        // A write into a full, stalled register is lost; one coinciding with the handshake replaces it
        if (wr) begin
            if (valid_q && !ready_i) begin
                ovf_d = 1'b1;
            end else begin
                data_d  = {{(16-SAMPLE_W){1'b0}}, wdata};
                valid_d = 1'b1;
            end
        end
`ifdef DAQ_ACQ_HDR_EN
        if (trig) begin
            data_d  = hdr;
            valid_d = 1'b1;
        end
`endif
        if (abort_ok) begin
            valid_d    = 1'b0;
            cnt_d      = '0;
            dcnt_d     = '0;
            prev_vld_d = 1'b0;
            ovf_d      = ovf_q;
`ifdef DAQ_ACQ_HDR_EN
            skid_vld_d = 1'b0;
`endif
        end
    end

    // Datapath registers
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            num_q      <= '0;
            decim_q    <= '0;
            src_q      <= 1'b0;
            level_q    <= '0;
            prev_q     <= '0;
            prev_vld_q <= 1'b0;
            dcnt_q     <= '0;
            cnt_q      <= '0;
            data_q     <= '0;
            valid_q    <= 1'b0;
            done_q     <= 1'b0;
            ovf_q      <= 1'b0;
        end else begin
            num_q      <= num_d;
            decim_q    <= decim_d;
            src_q      <= src_d;
            level_q    <= level_d;
            prev_q     <= prev_d;
            prev_vld_q <= prev_vld_d;
            dcnt_q     <= dcnt_d;
            cnt_q      <= cnt_d;
            data_q     <= data_d;
            valid_q    <= valid_d;
            done_q     <= done_d;
            ovf_q      <= ovf_d;
        end
    end

`ifdef DAQ_ACQ_HDR_EN
    // Skid register delaying kept samples by one cycle behind the header
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            skid_q     <= '0;
            skid_vld_q <= 1'b0;
        end else begin
            skid_q     <= skid_d;
            skid_vld_q <= skid_vld_d;
        end
    end
`endif
endmodule

// File: tb/tb_daq_acq_ctrl.sv
// tb_daq_acq_ctrl: table-driven bursts checked through a word scoreboard, plus stall, abort and reset sequences.
module tb_daq_acq_ctrl;
    logic        clk_i = 1'b0;
    logic        rst_n_i = 1'b0;
    logic [11:0] ad_data_i = '0;
    logic        start_i = 1'b0;
    logic        abort_i = 1'b0;
    logic [15:0] sample_num_i = '0;
    logic [7:0]  decim_i = '0;
    logic        trig_src_i = 1'b0;
    logic [11:0] trig_level_i = '0;
    logic [15:0] data_o;
    logic        valid_o;
    logic        ready_i = 1'b1;
    logic        busy_o;
    logic        done_o;
    logic        ovf_o;

    daq_acq_ctrl dut (
        .clk_i(clk_i), .rst_n_i(rst_n_i), .ad_data_i(ad_data_i),
        .start_i(start_i), .abort_i(abort_i), .sample_num_i(sample_num_i),
        .decim_i(decim_i), .trig_src_i(trig_src_i), .trig_level_i(trig_level_i),
        .data_o(data_o), .valid_o(valid_o), .ready_i(ready_i),
        .busy_o(busy_o), .done_o(done_o), .ovf_o(ovf_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic             src;
        logic [11:0]      level;
        logic [15:0]      num;
        logic [7:0]       decim;
        logic [0:7][11:0] samp;
        int               nexp;
        logic [0:3][15:0] exp;
    } row_t;

    localparam logic [0:7][11:0] RAMP = {12'h0, 12'h1, 12'h2, 12'h3, 12'h4, 12'h5, 12'h6, 12'h7};

    row_t        tbl [8];
    logic [15:0] exp_q [$];
    int          checks = 0, failures = 0;
    int          cyc = 0, first_hs = 0, last_hs = 0, done_cyc = 0, done_cnt = 0, hs_cnt = 0;
    bit          mon_en = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    always @(posedge clk_i) cyc <= cyc + 1;

    // Scoreboard: every accepted word is popped against the expectations queued at start
    always @(negedge clk_i) begin
        if (mon_en && rst_n_i) begin
            if (valid_o && ready_i) begin
                if (hs_cnt == 0) first_hs = cyc;
                last_hs = cyc;
                hs_cnt++;
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL extra_word: got %0h, expected no word", data_o);
                end else begin
                    chk("word", {16'h0, data_o}, {16'h0, exp_q.pop_front()});
                end
            end
            if (done_o) begin
                done_cnt++;
                done_cyc = cyc;
            end
        end
    end

    task automatic start_burst(input logic src, input logic [11:0] lvl, input logic [15:0] num,
                               input logic [7:0] dec);
        trig_src_i   = src;
        trig_level_i = lvl;
        sample_num_i = num;
        decim_i      = dec;
        start_i      = 1'b1;
        @(posedge clk_i);
        #1 start_i = 1'b0;
    endtask

    task automatic run_row(input row_t r, input int id);
        int d;
        d = r.decim == 0 ? 1 : int'(r.decim);
        for (int i = 0; i < r.nexp; i++) exp_q.push_back(r.exp[i]);
        hs_cnt   = 0;
        done_cnt = 0;
        ready_i  = 1'b1;
        mon_en   = 1'b1;
        start_burst(r.src, r.level, r.num, r.decim);
        for (int k = 0; k < 24; k++) begin
            ad_data_i = k < 8 ? r.samp[k] : 12'h0;
            @(posedge clk_i);
            #1;
        end
        mon_en = 1'b0;
        chk($sformatf("row%0d_words_left", id), exp_q.size(), 0);
        chk($sformatf("row%0d_words_seen", id), hs_cnt, r.nexp);
        chk($sformatf("row%0d_done_count", id), done_cnt, 1);
        chk($sformatf("row%0d_done_delay", id), done_cyc - last_hs, 1);
        chk($sformatf("row%0d_word_span", id), last_hs - first_hs, (r.nexp - 1) * d);
        chk($sformatf("row%0d_ovf", id), ovf_o, 0);
        chk($sformatf("row%0d_busy", id), busy_o, 0);
        exp_q.delete();
    endtask

    initial begin
        tbl[0] = '{1'b0, 12'h000, 16'd4, 8'd1, RAMP, 4, {16'h000, 16'h001, 16'h002, 16'h003}};
        tbl[1] = '{1'b1, 12'h800, 16'd2, 8'd1,
                   {12'h7F0, 12'h7FF, 12'h800, 12'h900, 12'hA00, 12'hB00, 12'hC00, 12'hD00},
                   2, {16'h800, 16'h900, 16'h0, 16'h0}};
        tbl[2] = '{1'b0, 12'h000, 16'd3, 8'd3, RAMP, 3, {16'h000, 16'h003, 16'h006, 16'h0}};
        tbl[3] = '{1'b1, 12'h800, 16'd2, 8'd1,
                   {12'h900, 12'h100, 12'h850, 12'h860, 12'h870, 12'h880, 12'h890, 12'h8A0},
                   2, {16'h850, 16'h860, 16'h0, 16'h0}};
        tbl[4] = '{1'b1, 12'h800, 16'd1, 8'd1,
                   {12'h800, 12'h800, 12'h7FF, 12'h801, 12'h900, 12'h910, 12'h920, 12'h930},
                   1, {16'h801, 16'h0, 16'h0, 16'h0}};
        tbl[5] = '{1'b0, 12'h000, 16'd3, 8'd0, RAMP, 3, {16'h000, 16'h001, 16'h002, 16'h0}};
        tbl[6] = '{1'b0, 12'h000, 16'd1, 8'd1, RAMP, 1, {16'h000, 16'h0, 16'h0, 16'h0}};
        tbl[7] = '{1'b1, 12'h004, 16'd2, 8'd2, RAMP, 2, {16'h004, 16'h006, 16'h0, 16'h0}};

        repeat (3) @(negedge clk_i);
        chk("reset_valid", valid_o, 0);
        chk("reset_busy", busy_o, 0);
        chk("reset_done", done_o, 0);
        chk("reset_ovf", ovf_o, 0);
        chk("reset_data", data_o, 0);
        @(posedge clk_i);
        #1 rst_n_i = 1'b1;

        for (int i = 0; i < 8; i++) run_row(tbl[i], i);

        // Stalled sink: first word held, later kept samples dropped, done after the handshake
        exp_q.push_back(16'h000);
        hs_cnt   = 0;
        done_cnt = 0;
        ready_i  = 1'b0;
        mon_en   = 1'b1;
        start_burst(1'b0, 12'h0, 16'd3, 8'd1);
        for (int k = 0; k < 8; k++) begin
            ad_data_i = 12'(k);
            @(posedge clk_i);
            #1;
        end
        @(negedge clk_i);
        chk("stall_data", data_o, 16'h000);
        chk("stall_valid", valid_o, 1);
        chk("stall_ovf", ovf_o, 1);
        chk("stall_busy", busy_o, 1);
        chk("stall_no_done", done_cnt, 0);
        @(posedge clk_i);
        #1 ready_i = 1'b1;
        repeat (4) @(posedge clk_i);
        #1 mon_en = 1'b0;
        chk("stall_done_count", done_cnt, 1);
        chk("stall_words_left", exp_q.size(), 0);
        chk("stall_ovf_sticky", ovf_o, 1);
        chk("stall_idle", busy_o, 0);

        // Continuous burst with a stall, then abort: no done, ovf held, valid cleared
        ready_i = 1'b0;
        start_burst(1'b0, 12'h0, 16'd0, 8'd1);
        @(negedge clk_i);
        chk("restart_ovf_clear", ovf_o, 0);
        chk("restart_busy", busy_o, 1);
        for (int k = 0; k < 6; k++) begin
            @(posedge clk_i);
            #1 ad_data_i = 12'(k + 1);
        end
        @(negedge clk_i);
        chk("cont_ovf", ovf_o, 1);
        chk("cont_valid", valid_o, 1);
        @(posedge clk_i);
        #1 abort_i = 1'b1;
        @(posedge clk_i);
        #1 abort_i = 1'b0;
        @(negedge clk_i);
        chk("abort_busy", busy_o, 0);
        chk("abort_valid", valid_o, 0);
        chk("abort_ovf_held", ovf_o, 1);
        for (int k = 0; k < 3; k++) begin
            chk("abort_no_done", done_o, 0);
            @(negedge clk_i);
        end
        @(posedge clk_i);
        #1 begin start_i = 1'b1; abort_i = 1'b1; end
        @(posedge clk_i);
        #1 begin start_i = 1'b0; abort_i = 1'b0; end
        @(negedge clk_i);
        chk("start_abort_busy", busy_o, 0);
        chk("start_abort_ovf", ovf_o, 1);

        // Reset mid-capture with a word pending
        ready_i = 1'b0;
        @(posedge clk_i);
        #1;
        start_burst(1'b0, 12'h0, 16'd0, 8'd1);
        repeat (4) @(posedge clk_i);
        @(negedge clk_i);
        chk("pre_reset_valid", valid_o, 1);
        rst_n_i = 1'b0;
        #1;
        chk("mid_reset_valid", valid_o, 0);
        chk("mid_reset_busy", busy_o, 0);
        chk("mid_reset_ovf", ovf_o, 0);
        chk("mid_reset_done", done_o, 0);
        @(posedge clk_i);
        #1;
        chk("mid_reset_edge_busy", busy_o, 0);
        chk("mid_reset_edge_valid", valid_o, 0);
        rst_n_i = 1'b1;
        ready_i = 1'b1;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
